// File: rtl/png_stream_pkg.sv
// png_stream_pkg
// Shared definitions for the PNG byte streamer:
//   state_t          - streamer FSM states (IDLE / START / STREAM)
//   ORDER_*          - encodings for the MSB_FIRST byte-order parameter
//   nb_width()       - width of a byte-count field able to hold DATA_W/8
package png_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam bit ORDER_LSB_FIRST = 1'b0;
    localparam bit ORDER_MSB_FIRST = 1'b1;

    function automatic int nb_width(input int data_w);
        return $clog2(data_w / 8 + 1);
    endfunction

endpackage

// File: rtl/png_word_slot.sv
// png_word_slot
// One word storage entry (data, byte count, first flag, valid).
// Ports:
//   clk, rstn          clock, async active-low reset
//   load               capture d_* and mark the entry valid (wins over clear)
//   clear              mark the entry empty
//   d_data/d_nbytes/d_first   word to capture
//   data/nbytes/first/valid   stored entry
module png_word_slot #(
    parameter int DATA_W = 552,
    parameter int NB_W   = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [NB_W-1:0]   d_nbytes,
    input  logic              d_first,
    output logic [DATA_W-1:0] data,
    output logic [NB_W-1:0]   nbytes,
    output logic              first,
    output logic              valid
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data   <= '0;
            nbytes <= '0;
            first  <= 1'b0;
            valid  <= 1'b0;
        end else if (load) begin
            data   <= d_data;
            nbytes <= d_nbytes;
            first  <= d_first;
            valid  <= 1'b1;
        end else if (clear) begin
            first  <= 1'b0;
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/png_byte_streamer.sv
// png_byte_streamer
// Serialises DATA_W-bit words into the PNG decoder byte interface.
// A two-slot buffer (active + pending) keeps bytes flowing across word
// boundaries; a word flagged s_first is preceded by a one-cycle o_start.
// Ports:
//   clk, rstn                          clock, async active-low reset
//   s_valid/s_ready/s_data/s_nbytes/s_first   word input (valid/ready)
//   o_start/o_valid/o_ready/o_byte     byte output to decoder
//   busy                               a word is held in either slot
//   bytes_sent                         running count of byte handshakes
module png_byte_streamer
    import png_stream_pkg::*;
#(
    parameter int  DATA_W    = 552,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int NB_W      = nb_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [NB_W-1:0]   s_nbytes,
    input  logic              s_first,
    output logic              o_start,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [7:0]        o_byte,
    output logic              busy,
    output logic [31:0]       bytes_sent
);

    localparam int              NBYTES_MAX = DATA_W / 8;
    localparam logic [NB_W-1:0] NB_MAX     = NB_W'(NBYTES_MAX);
    localparam int              BIT_W      = $clog2(DATA_W);

    state_t            state;
    logic [NB_W-1:0]   idx;

    logic [DATA_W-1:0] act_data;
    logic [NB_W-1:0]   act_nbytes;
    logic              act_first;
    logic              act_valid;
    logic [DATA_W-1:0] pend_data;
    logic [NB_W-1:0]   pend_nbytes;
    logic              pend_first;
    logic              pend_v;

    logic [NB_W-1:0]   in_nbytes;
    logic              accept;
    logic              handshake;
    logic              last_byte;
    logic              release_act;
    logic              act_from_pend;
    logic              act_from_in;
    logic              pend_load;
    logic              act_clear;
    logic [DATA_W-1:0] act_d_data;
    logic [NB_W-1:0]   act_d_nbytes;
    logic              act_d_first;
    logic [BIT_W-1:0]  bit_lo;

    // Out-of-range counts mean "full word".
    assign in_nbytes = ((s_nbytes == '0) || (s_nbytes > NB_MAX)) ? NB_MAX : s_nbytes;

    // s_ready only looks at the pending flag, so o_ready never reaches it.
    assign s_ready     = !pend_v;
    assign accept      = s_valid && s_ready;
    assign handshake   = o_valid && o_ready;
    assign last_byte   = (idx == (act_nbytes - NB_W'(1)));
    assign release_act = handshake && last_byte;

    // pend_v blocks accept, so the two active-load sources never collide.
    assign act_from_pend = release_act && pend_v;
    assign act_from_in   = accept && ((state == ST_IDLE) || release_act);
    assign pend_load     = accept && !((state == ST_IDLE) || release_act);
    assign act_clear     = release_act && !pend_v && !accept;

    assign act_d_data   = act_from_pend ? pend_data   : s_data;
    assign act_d_nbytes = act_from_pend ? pend_nbytes : in_nbytes;
    assign act_d_first  = act_from_pend ? pend_first  : s_first;

    png_word_slot #(.DATA_W(DATA_W), .NB_W(NB_W)) u_active (
        .clk      (clk),
        .rstn     (rstn),
        .load     (act_from_pend || act_from_in),
        .clear    (act_clear),
        .d_data   (act_d_data),
        .d_nbytes (act_d_nbytes),
        .d_first  (act_d_first),
        .data     (act_data),
        .nbytes   (act_nbytes),
        .first    (act_first),
        .valid    (act_valid)
    );

    png_word_slot #(.DATA_W(DATA_W), .NB_W(NB_W)) u_pending (
        .clk      (clk),
        .rstn     (rstn),
        .load     (pend_load),
        .clear    (act_from_pend),
        .d_data   (s_data),
        .d_nbytes (in_nbytes),
        .d_first  (s_first),
        .data     (pend_data),
        .nbytes   (pend_nbytes),
        .first    (pend_first),
        .valid    (pend_v)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            o_valid    <= 1'b0;
            bytes_sent <= '0;
        end else begin
            if (handshake) begin
                bytes_sent <= bytes_sent + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx     <= '0;
                        state   <= s_first ? ST_START : ST_STREAM;
                        o_valid <= !s_first;
                    end
                end
                ST_START: begin
                    state   <= ST_STREAM;
                    o_valid <= 1'b1;
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (last_byte) begin
                            idx <= '0;
                            if (pend_v) begin
                                state   <= pend_first ? ST_START : ST_STREAM;
                                o_valid <= !pend_first;
                            end else if (accept) begin
                                state   <= s_first ? ST_START : ST_STREAM;
                                o_valid <= !s_first;
                            end else begin
                                state   <= ST_IDLE;
                                o_valid <= 1'b0;
                            end
                        end else begin
                            idx <= idx + NB_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

    // START is only entered for a word whose first flag is set; the AND
    // keeps the pulse tied to the word actually held.
    assign o_start = (state == ST_START) && act_first;

    always_comb begin
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
            bit_lo = BIT_W'(DATA_W - 8 - 8 * int'(idx));
        end else begin
            bit_lo = BIT_W'(8 * int'(idx));
        end
    end

    assign o_byte = o_valid ? act_data[bit_lo +: 8] : 8'h00;
    assign busy   = (state != ST_IDLE) || act_valid || pend_v;

endmodule

// File: tb/tb_png_byte_streamer.sv
module tb_png_byte_streamer;

    logic         clk = 1'b0;
    logic         rstn;

    logic         s_valid, s_ready, s_first;
    logic [551:0] s_data;
    logic [6:0]   s_nbytes;
    logic         o_start, o_valid, o_ready, busy;
    logic [7:0]   o_byte;
    logic [31:0]  bytes_sent;

    logic         m_s_valid, m_s_ready, m_s_first;
    logic [31:0]  m_s_data;
    logic [2:0]   m_s_nbytes;
    logic         m_o_start, m_o_valid, m_o_ready, m_busy;
    logic [7:0]   m_o_byte;
    logic [31:0]  m_bytes_sent;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_sent = 0;

    always #5 clk = ~clk;

    png_byte_streamer #(.DATA_W(552), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_nbytes(s_nbytes), .s_first(s_first),
        .o_start(o_start), .o_valid(o_valid), .o_ready(o_ready),
        .o_byte(o_byte), .busy(busy), .bytes_sent(bytes_sent)
    );

    png_byte_streamer #(.DATA_W(32), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstn(rstn),
        .s_valid(m_s_valid), .s_ready(m_s_ready), .s_data(m_s_data),
        .s_nbytes(m_s_nbytes), .s_first(m_s_first),
        .o_start(m_o_start), .o_valid(m_o_valid), .o_ready(m_o_ready),
        .o_byte(m_o_byte), .busy(m_busy), .bytes_sent(m_bytes_sent)
    );

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_start !== 1'b0) begin failures++; $display("FAIL reset_o_start got=%b exp=0", o_start); end
        checks++; if (o_byte !== 8'h00) begin failures++; $display("FAIL reset_o_byte got=%02h exp=00", o_byte); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bytes_sent !== 32'd0) begin failures++; $display("FAIL reset_bytes_sent got=%0d exp=0", bytes_sent); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (m_s_ready !== 1'b1 || m_o_valid !== 1'b0) begin failures++; $display("FAIL reset_m got=%b%b exp=10", m_s_ready, m_o_valid); end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [551:0] w;
        w = '0;
        for (int k = 0; k < 69; k++) w[k*8 +: 8] = 8'(k + 1);
        @(negedge clk);
        s_valid = 1'b1; s_data = w; s_nbytes = 7'd69; s_first = 1'b1; o_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0;
        checks++; if (o_start !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL single_start got=start%b valid%b exp=start1 valid0", o_start, o_valid); end
        for (int k = 0; k < 69; k++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_start !== 1'b0 || o_byte !== 8'(k + 1)) begin
                failures++;
                $display("FAIL single_byte[%0d] got=v%b s%b %02h exp=v1 s0 %02h", k, o_valid, o_start, o_byte, 8'(k + 1));
            end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_last got=%b exp=1", busy); end
        exp_sent += 69;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_end got=v%b busy%b exp=v0 busy0", o_valid, busy); end
        checks++; if (bytes_sent !== exp_sent) begin failures++; $display("FAIL single_count got=%0d exp=%0d", bytes_sent, exp_sent); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22};
        @(negedge clk);
        s_valid = 1'b1; s_data = '0; s_data[23:0] = 24'h131211; s_nbytes = 7'd3; s_first = 1'b0; o_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_byte !== exp_b[c]) begin
                failures++;
                $display("FAIL b2b_byte[%0d] got=v%b %02h exp=v1 %02h", c, o_valid, o_byte, exp_b[c]);
            end
            if (c == 0) begin
                checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_c0 got=%b exp=1", s_ready); end
                s_data = '0; s_data[15:0] = 16'h2221; s_nbytes = 7'd2;
            end else if (c == 1 || c == 2) begin
                checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_pending[%0d] got=%b exp=0", c, s_ready); end
                s_valid = 1'b0;
            end
        end
        exp_sent += 5;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || busy !== 1'b0 || bytes_sent !== exp_sent) begin failures++; $display("FAIL b2b_end got=v%b busy%b cnt%0d exp=v0 busy0 cnt%0d", o_valid, busy, bytes_sent, exp_sent); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [6];
        logic       rdy   [6];
        exp_b = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04};
        rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        s_valid = 1'b1; s_data = '0; s_data[31:0] = 32'h04030201; s_nbytes = 7'd4; s_first = 1'b0; o_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || o_byte !== exp_b[c]) begin
                failures++;
                $display("FAIL bp_byte[%0d] got=v%b %02h exp=v1 %02h", c, o_valid, o_byte, exp_b[c]);
            end
            o_ready = rdy[c];
        end
        exp_sent += 4;
        @(negedge clk);
        o_ready = 1'b1;
        checks++; if (o_valid !== 1'b0 || bytes_sent !== exp_sent) begin failures++; $display("FAIL bp_end got=v%b cnt%0d exp=v0 cnt%0d", o_valid, bytes_sent, exp_sent); end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_b [8];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        m_s_valid = 1'b1; m_s_data = 32'hAABBCCDD; m_s_nbytes = 3'd4; m_s_first = 1'b0; m_o_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                m_s_data = 32'h11223344; m_s_nbytes = 3'd0;
            end else begin
                m_s_valid = 1'b0;
            end
            checks++;
            if (m_o_valid !== 1'b1 || m_o_byte !== exp_b[c]) begin
                failures++;
                $display("FAIL msb_byte[%0d] got=v%b %02h exp=v1 %02h", c, m_o_valid, m_o_byte, exp_b[c]);
            end
        end
        @(negedge clk);
        checks++; if (m_o_valid !== 1'b0 || m_busy !== 1'b0 || m_bytes_sent !== 32'd8) begin failures++; $display("FAIL msb_end got=v%b busy%b cnt%0d exp=v0 busy0 cnt8", m_o_valid, m_busy, m_bytes_sent); end
    endtask

    task automatic test_first_mid_stream();
        logic [7:0] exp_b [6];
        logic       exp_v [6];
        int         starts;
        exp_b = '{8'h31, 8'h32, 8'h33, 8'h00, 8'h41, 8'h42};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        starts = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = '0; s_data[23:0] = 24'h333231; s_nbytes = 7'd3; s_first = 1'b0; o_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                s_data = '0; s_data[15:0] = 16'h4241; s_nbytes = 7'd2; s_first = 1'b1;
            end else begin
                s_valid = 1'b0; s_first = 1'b0;
            end
            if (o_start === 1'b1) starts++;
            checks++;
            if (o_valid !== exp_v[c] || o_start !== !exp_v[c] || (exp_v[c] && o_byte !== exp_b[c])) begin
                failures++;
                $display("FAIL midfirst[%0d] got=v%b s%b %02h exp=v%b s%b %02h", c, o_valid, o_start, o_byte, exp_v[c], !exp_v[c], exp_b[c]);
            end
        end
        checks++; if (starts != 1) begin failures++; $display("FAIL midfirst_start_count got=%0d exp=1", starts); end
        exp_sent += 5;
        // one-byte word releasing while a first-flagged word is offered directly
        @(negedge clk);
        s_valid = 1'b1; s_data = '0; s_data[7:0] = 8'h51; s_nbytes = 7'd1; s_first = 1'b0;
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h51) begin failures++; $display("FAIL direct_a got=v%b %02h exp=v1 51", o_valid, o_byte); end
        s_data = '0; s_data[15:0] = 16'h6261; s_nbytes = 7'd2; s_first = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0;
        checks++; if (o_start !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL direct_start got=s%b v%b exp=s1 v0", o_start, o_valid); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h61) begin failures++; $display("FAIL direct_b0 got=v%b %02h exp=v1 61", o_valid, o_byte); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h62) begin failures++; $display("FAIL direct_b1 got=v%b %02h exp=v1 62", o_valid, o_byte); end
        exp_sent += 3;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || bytes_sent !== exp_sent) begin failures++; $display("FAIL direct_end got=v%b cnt%0d exp=v0 cnt%0d", o_valid, bytes_sent, exp_sent); end
    endtask

    task automatic test_reset_mid();
        logic [551:0] w;
        w = '0;
        for (int k = 0; k < 69; k++) w[k*8 +: 8] = 8'(k + 1);
        @(negedge clk);
        s_valid = 1'b1; s_data = w; s_nbytes = 7'd69; s_first = 1'b0; o_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || o_byte !== 8'(k + 1)) begin
                failures++;
                $display("FAIL rmid_byte[%0d] got=v%b %02h exp=v1 %02h", k, o_valid, o_byte, 8'(k + 1));
            end
        end
        rstn = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_start !== 1'b0 || o_byte !== 8'h00) begin failures++; $display("FAIL rmid_outputs got=v%b s%b %02h exp=v0 s0 00", o_valid, o_start, o_byte); end
        checks++; if (busy !== 1'b0 || s_ready !== 1'b1 || bytes_sent !== 32'd0) begin failures++; $display("FAIL rmid_state got=busy%b rdy%b cnt%0d exp=busy0 rdy1 cnt0", busy, s_ready, bytes_sent); end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_after got=v%b busy%b exp=v0 busy0", o_valid, busy); end
        s_valid = 1'b1; s_data = '0; s_data[23:0] = 24'hA3A2A1; s_nbytes = 7'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || o_byte !== 8'(8'hA1 + k)) begin
                failures++;
                $display("FAIL rmid_new[%0d] got=v%b %02h exp=v1 %02h", k, o_valid, o_byte, 8'(8'hA1 + k));
            end
        end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || bytes_sent !== 32'd3) begin failures++; $display("FAIL rmid_count got=v%b cnt%0d exp=v0 cnt3", o_valid, bytes_sent); end
    endtask

    initial begin
        s_valid = 1'b0; s_data = '0; s_nbytes = '0; s_first = 1'b0; o_ready = 1'b1;
        m_s_valid = 1'b0; m_s_data = '0; m_s_nbytes = '0; m_s_first = 1'b0; m_o_ready = 1'b1;
        rstn = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_first_mid_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/png_byte_streamer.md
# png_byte_streamer

Parametrised wide-word to byte serializer that feeds the PNG decoder's byte input (`istart`/`ivalid`/`iready`/`ibyte`). Accepts DATA_W-bit words with a valid/ready handshake and a per-word byte count. Honours decoder backpressure and emits a start pulse at each new image stream. A two-entry word buffer lets the producer load the next word while the current one drains, so bytes flow without gaps across word boundaries.

## Interface
- DATA_W, 552, input word width; multiple of 8, ≥ 16
- MSB_FIRST, 0, 0: byte 0 = data[7:0]; 1: byte 0 = data[DATA_W-1 -: 8]
- NB_W, $clog2(DATA_W/8+1), width of byte-count field (derived, not overridden)
- clk  in  1  single clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- s_valid  in  1  input word valid
- s_ready  out  1  word accepted when s_valid && s_ready
- s_data  in  DATA_W  input word
- s_nbytes  in  NB_W  valid bytes in word, 1..DATA_W/8; 0 or > DATA_W/8 means DATA_W/8
- s_first  in  1  word begins a new image stream
- o_start  out  1  one-cycle stream-start pulse (to decoder istart)
- o_valid  out  1  byte valid (to ivalid)
- o_ready  in  1  decoder ready (from iready)
- o_byte  out  8  current byte (to ibyte)
- busy  out  1  any word held
- bytes_sent  out  32  count of byte handshakes, wraps at 2^32

## Operation
- Storage: active slot (data, nbytes, first) plus pending slot (data, nbytes, first, pend_v); byte index idx, NB_W bits.
- s_ready = !pend_v.
- Accepted word goes to the active slot if the active slot is empty or releasing this cycle; otherwise it goes to pending.
- FSM states:
  - IDLE: no active word. On accept, go to START if s_first, else STREAM; idx = 0.
  - START: o_start = 1, o_valid = 0 for exactly one cycle, then STREAM.
  - STREAM: o_valid = 1; o_byte = active byte idx. A handshake (o_valid && o_ready) increments idx and bytes_sent.
- On handshake of the last byte (idx == nbytes-1) the active slot releases:
  - pending valid: move pending to active, clear pend_v, idx = 0; go to START if its first flag is set, else stay in STREAM.
  - else, s_valid present: load the input word directly into active (same START/STREAM rule).
  - else: go to IDLE.
- s_first on a word loaded while in STREAM still yields START before that word's first byte.
- busy = (state != IDLE) || pend_v.
- o_start is never asserted together with o_valid.

## Timing
- Reset values: o_valid 0, o_start 0, o_byte 8'h00, busy 0, bytes_sent 0, s_ready 1, state IDLE, both slots cleared.
- Reset mid-stream discards both slots immediately; no further bytes are emitted.
- Latency, accept to first o_valid: 1 cycle without s_first, 2 cycles with s_first.
- Back-to-back words without s_first: no idle cycle between the last byte of one word and byte 0 of the next.
- o_byte and o_valid are held stable while o_valid && !o_ready.
- o_valid does not depend combinationally on o_ready; no combinational path from o_ready to s_ready.
- Throughput: 1 byte/cycle while o_ready is high.

## Structure
- Package png_stream_pkg holds the FSM state enum (IDLE/START/STREAM), the MSB_FIRST encoding constants, and the clog2-based NB_W helper.
- Sub-module png_word_slot: one storage entry (data, nbytes, first, valid) with load/clear. Instantiated twice, for the active and pending slots.
- Byte select is an indexed part-select on the active data; no shift of the full word.

## Test plan
- Single word, DATA_W=552, s_nbytes=69, s_first=1, o_ready=1:
  - one o_start pulse, then 69 bytes in LSB order;
  - bytes_sent = 69, busy falls 1 cycle after the last byte.
- Two words with s_nbytes=3 then 2, neither with s_first, sent back-to-back:
  - bytes appear on consecutive cycles with no gap;
  - s_ready deasserts while pending is held.
- Backpressure with o_ready toggling 1,0,0,1 over word 0x…0403_0201 → o_byte holds 8'h02 through the stall, then sequence 01,02,03,04.
- MSB_FIRST=1, DATA_W=32, data 32'hAABBCCDD, nbytes=4 → AA,BB,CC,DD.
- Second word carries s_first while the first is streaming → exactly one o_start cycle (o_valid=0) between the two words.
- rstn asserted mid-word at byte 10, then released → all outputs at reset values, s_ready=1, next word starts at byte 0.
